us_cmd_dispatch: RTL and testbench

US_CMD_DISPATCH -- requirements
Module: us_cmd_dispatch

---
 rtl/us_cmd_dispatch.sv | 199 +++++++++++++++++++
 tb/tb_us_cmd_dispatch.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/us_cmd_dispatch.sv
// us_cmd_dispatch: pops upstream commands from an FWFT FIFO and sequences CPL/CPLD/WR32
// requests to the TX engine, splitting large writes into MPS-sized TLPs.
`ifndef US_CMD_INVALID
`define US_CMD_INVALID   2'b00
`define US_CMD_CPL_TYPE  2'b01
`define US_CMD_CPLD_TYPE 2'b10
`define US_CMD_WR32_TYPE 2'b11
`endif

// state | meaning
// IDLE  | waiting for a command; the pop cycle has rd_en high
// CPL   | completion request held until tx_ack
// CPLD  | completion-with-data request held until tx_ack
// WR    | issuing WR32 TLPs; wr_req low for one cycle between TLPs
// DONE  | write finished, one-cycle completion pulse
module us_cmd_dispatch #(
   parameter int MPS_BYTES = 128
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        us_cmd_fifo_empty_i,
   input  logic [63:0] us_cmd_fifo_dout_i,
   output logic        us_cmd_fifo_rd_en_o,
   output logic        cpl_req_o,
   output logic        cpld_req_o,
   output logic        wr_req_o,
   input  logic        tx_ack_i,
   output logic [54:0] req_info_o,
   output logic [31:0] wr_addr_o,
   output logic [9:0]  wr_len_dw_o,
   output logic        up_wr_cmd_compl_o,
   output logic [1:0]  cmd_id_o,
   output logic        busy_o,
   output logic [7:0]  drop_cnt_o
);
   localparam logic [4:0] MPS_LOG2 = (MPS_BYTES == 512) ? 5'd9 :
                                     (MPS_BYTES == 256) ? 5'd8 : 5'd7;
   localparam logic [9:0] MPS_DW   = 10'(MPS_BYTES / 4);

   typedef enum logic [2:0] {IDLE, CPL, CPLD, WR, DONE} state_t;

   state_t      r_state, w_state_nxt;
   logic        r_rd_en, w_rd_en_nxt;
   logic        r_cpl_req, w_cpl_req_nxt;
   logic        r_cpld_req, w_cpld_req_nxt;
   logic        r_wr_req, w_wr_req_nxt;
   logic        r_compl, w_compl_nxt;
   logic        r_busy, w_busy_nxt;
   logic [7:0]  r_drop_cnt, w_drop_cnt_nxt;
   logic [1:0]  r_cmd_id, w_cmd_id_nxt;
   logic [54:0] r_req_info, w_req_info_nxt;
   logic [31:0] r_wr_addr, w_wr_addr_nxt;
   logic [9:0]  r_wr_len_dw, w_wr_len_dw_nxt;
   logic [13:0] r_tlp_left, w_tlp_left_nxt;

   logic [1:0]  w_cmd_type;
   logic [4:0]  w_len_raw, w_len_clamp, w_len_eff;
   logic [9:0]  w_cmd_len_dw;
   logic [13:0] w_cmd_tlps;

   assign w_cmd_type  = us_cmd_fifo_dout_i[63:62];
   assign w_len_raw   = us_cmd_fifo_dout_i[61:57];
   assign w_len_clamp = (w_len_raw > 5'd20) ? 5'd20 : w_len_raw;
   assign w_len_eff   = (w_len_clamp < 5'd2) ? 5'd2 : w_len_clamp;

   // Writes no larger than MPS go out as a single TLP; larger ones as 2^n MPS-sized TLPs.
   always_comb begin
      w_cmd_len_dw = MPS_DW;
      w_cmd_tlps   = 14'd1;
      if (w_len_eff <= MPS_LOG2) begin
         w_cmd_len_dw = 10'd1 << (w_len_eff - 5'd2);
      end else begin
         w_cmd_tlps = 14'd1 << (w_len_eff - MPS_LOG2);
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_rd_en_nxt     = 1'b0;
      w_cpl_req_nxt   = r_cpl_req;
      w_cpld_req_nxt  = r_cpld_req;
      w_wr_req_nxt    = r_wr_req;
      w_compl_nxt     = 1'b0;
      w_drop_cnt_nxt  = r_drop_cnt;
      w_cmd_id_nxt    = r_cmd_id;
      w_req_info_nxt  = r_req_info;
      w_wr_addr_nxt   = r_wr_addr;
      w_wr_len_dw_nxt = r_wr_len_dw;
      w_tlp_left_nxt  = r_tlp_left;
      unique case (r_state)
         IDLE: begin
            if (r_rd_en) begin
               unique case (w_cmd_type)
                  `US_CMD_CPL_TYPE: begin
                     w_state_nxt    = CPL;
                     w_cpl_req_nxt  = 1'b1;
                     w_req_info_nxt = us_cmd_fifo_dout_i[54:0];
                     w_cmd_id_nxt   = us_cmd_fifo_dout_i[56:55];
                  end
                  `US_CMD_CPLD_TYPE: begin
                     w_state_nxt    = CPLD;
                     w_cpld_req_nxt = 1'b1;
                     w_req_info_nxt = us_cmd_fifo_dout_i[54:0];
                     w_cmd_id_nxt   = us_cmd_fifo_dout_i[56:55];
                  end
                  `US_CMD_WR32_TYPE: begin
                     w_state_nxt     = WR;
                     w_wr_req_nxt    = 1'b1;
                     w_wr_addr_nxt   = {us_cmd_fifo_dout_i[31:2], 2'b00};
                     w_wr_len_dw_nxt = w_cmd_len_dw;
                     w_tlp_left_nxt  = w_cmd_tlps;
                     w_cmd_id_nxt    = us_cmd_fifo_dout_i[56:55];
                  end
                  default: begin
                     if (r_drop_cnt != 8'hFF) w_drop_cnt_nxt = r_drop_cnt + 8'd1;
                  end
               endcase
            end else if (!us_cmd_fifo_empty_i) begin
               w_rd_en_nxt = 1'b1;
            end
         end
         CPL: begin
            if (tx_ack_i) begin
               w_cpl_req_nxt = 1'b0;
               w_state_nxt   = IDLE;
            end
         end
         CPLD: begin
            if (tx_ack_i) begin
               w_cpld_req_nxt = 1'b0;
               w_state_nxt    = IDLE;
            end
         end
         WR: begin
            if (r_wr_req) begin
               if (tx_ack_i) begin
                  w_wr_req_nxt = 1'b0;
                  if (r_tlp_left == 14'd1) begin
                     w_state_nxt = DONE;
                     w_compl_nxt = 1'b1;
                  end else begin
                     w_wr_addr_nxt  = r_wr_addr + {20'd0, r_wr_len_dw, 2'b00};
                     w_tlp_left_nxt = r_tlp_left - 14'd1;
                  end
               end
            end else begin
               w_wr_req_nxt = 1'b1;
            end
         end
         DONE: w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
      w_busy_nxt = (w_state_nxt != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_rd_en     <= 1'b0;
         r_cpl_req   <= 1'b0;
         r_cpld_req  <= 1'b0;
         r_wr_req    <= 1'b0;
         r_compl     <= 1'b0;
         r_busy      <= 1'b0;
         r_drop_cnt  <= 8'd0;
         r_cmd_id    <= 2'd0;
         r_req_info  <= 55'd0;
         r_wr_addr   <= 32'd0;
         r_wr_len_dw <= 10'd0;
         r_tlp_left  <= 14'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_rd_en     <= w_rd_en_nxt;
         r_cpl_req   <= w_cpl_req_nxt;
         r_cpld_req  <= w_cpld_req_nxt;
         r_wr_req    <= w_wr_req_nxt;
         r_compl     <= w_compl_nxt;
         r_busy      <= w_busy_nxt;
         r_drop_cnt  <= w_drop_cnt_nxt;
         r_cmd_id    <= w_cmd_id_nxt;
         r_req_info  <= w_req_info_nxt;
         r_wr_addr   <= w_wr_addr_nxt;
         r_wr_len_dw <= w_wr_len_dw_nxt;
         r_tlp_left  <= w_tlp_left_nxt;
      end
   end

   assign us_cmd_fifo_rd_en_o = r_rd_en;
   assign cpl_req_o           = r_cpl_req;
   assign cpld_req_o          = r_cpld_req;
   assign wr_req_o            = r_wr_req;
   assign up_wr_cmd_compl_o   = r_compl;
   assign busy_o              = r_busy;
   assign drop_cnt_o          = r_drop_cnt;
   assign cmd_id_o            = r_cmd_id;
   assign req_info_o          = r_req_info;
   assign wr_addr_o           = r_wr_addr;
   assign wr_len_dw_o         = r_wr_len_dw;
endmodule

// File: tb/tb_us_cmd_dispatch.sv
// tb_us_cmd_dispatch: command table plus corner-case sequences; a FIFO model feeds the DUT
// and a scoreboard of expected requests/completions is checked as the DUT raises them.
`ifndef US_CMD_INVALID
`define US_CMD_INVALID   2'b00
`define US_CMD_CPL_TYPE  2'b01
`define US_CMD_CPLD_TYPE 2'b10
`define US_CMD_WR32_TYPE 2'b11
`endif

module tb_us_cmd_dispatch;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        fifo_empty = 1'b1;
   logic [63:0] fifo_dout = 64'd0;
   logic        rd_en, cpl, cpld, wr, compl, busy;
   logic        tx_ack = 1'b0;
   logic [54:0] info;
   logic [31:0] waddr;
   logic [9:0]  wlen;
   logic [1:0]  cid;
   logic [7:0]  drop;

   us_cmd_dispatch #(.MPS_BYTES(128)) dut (
      .clk(clk), .rst_n(rst_n),
      .us_cmd_fifo_empty_i(fifo_empty), .us_cmd_fifo_dout_i(fifo_dout),
      .us_cmd_fifo_rd_en_o(rd_en),
      .cpl_req_o(cpl), .cpld_req_o(cpld), .wr_req_o(wr), .tx_ack_i(tx_ack),
      .req_info_o(info), .wr_addr_o(waddr), .wr_len_dw_o(wlen),
      .up_wr_cmd_compl_o(compl), .cmd_id_o(cid),
      .busy_o(busy), .drop_cnt_o(drop)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  typ;
      logic [4:0]  len;
      logic [1:0]  id;
      logic [54:0] pay;
      int          ack_dly;
      int          exp_tlps;
      logic [9:0]  exp_len_dw;
      logic [31:0] exp_addr0;
      logic [7:0]  exp_drop;
   } vec_t;

   typedef struct {
      int          kind;   // 0 CPL, 1 CPLD, 2 WR TLP, 3 completion pulse
      logic [54:0] info;
      logic [31:0] addr;
      logic [9:0]  len;
      logic [1:0]  id;
   } ev_t;

   int   checks = 0;
   int   errors = 0;
   ev_t  exp_q[$];
   logic [63:0] fifo_q[$];
   vec_t vt[$];

   int   ack_delay = 1;
   bit   ack_rand = 0;
   bit   spurious = 0;
   int   last_req_len = -1;
   int   compl_cnt = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic void fifo_refresh();
      fifo_empty = (fifo_q.size() == 0);
      fifo_dout  = (fifo_q.size() != 0) ? fifo_q[0] : 64'd0;
   endfunction

   task automatic push_cmd(input logic [63:0] w);
      fifo_q.push_back(w);
      fifo_refresh();
   endtask

   // FIFO model: the word shown in a cycle with rd_en high is consumed at that cycle's edge
   bit pop_pend = 0;
   always @(negedge clk) pop_pend = rd_en;
   always @(posedge clk) begin
      #1;
      if (pop_pend && rst_n && fifo_q.size() != 0) void'(fifo_q.pop_front());
      fifo_refresh();
   end

   // TX engine model: ack on the ack_delay-th cycle of each request
   bit ack_prev_req = 0;
   int ack_cnt = 0;
   int ack_target = 1;
   always @(negedge clk) begin
      if (rst_n && (cpl || cpld || wr)) begin
         if (!ack_prev_req) begin
            ack_target = ack_rand ? int'($urandom_range(1, 3)) : ack_delay;
            ack_cnt = 0;
         end
         ack_cnt++;
         tx_ack = (ack_cnt == ack_target);
      end else begin
         tx_ack = spurious;
      end
      ack_prev_req = rst_n && (cpl || cpld || wr);
   end

   task automatic ev_check(input int ak);
      ev_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_event actual=kind%0d required=none", ak);
      end else begin
         e = exp_q.pop_front();
         chk("ev_kind", ak, e.kind);
         chk("ev_cmd_id", cid, e.id);
         if (ak < 2) chk("ev_req_info", info, e.info);
         if (ak == 2) begin
            chk("ev_wr_addr", waddr, e.addr);
            chk("ev_wr_len_dw", wlen, e.len);
         end
      end
   endtask

   // Protocol monitor / scoreboard consumer
   logic        prev_any = 0, prev_rd = 0, prev_busy = 0, prev_compl = 0, prev_wr = 0, gap_pend = 0;
   logic [63:0] pop_word = 0;
   logic [98:0] prev_fields = 0;
   int          run_len = 0;
   always @(negedge clk) begin
      logic any;
      any = cpl || cpld || wr;
      if (!rst_n) begin
         prev_any = 0; prev_rd = 0; prev_busy = 0; prev_compl = 0; prev_wr = 0;
         gap_pend = 0; run_len = 0;
      end else begin
         if (any) chk("req_onehot", 32'(cpl) + 32'(cpld) + 32'(wr), 1);
         if (prev_rd) begin
            if (pop_word[63:62] == `US_CMD_INVALID) chk("invalid_no_req", {any, busy}, 2'b00);
            else chk("req_after_pop", {any, busy}, 2'b11);
         end
         if (rd_en) begin
            chk("pop_spacing", {prev_rd, prev_busy, busy}, 3'b000);
            pop_word = fifo_dout;
         end
         if (gap_pend) chk("wr_gap_reassert", wr, 1'b1);
         gap_pend = prev_wr && !wr && busy && !compl;
         if (any && !prev_any) ev_check(cpl ? 0 : (cpld ? 1 : 2));
         else if (any && prev_any) chk("fields_stable", {info, waddr, wlen, cid}, prev_fields);
         if (any) run_len++;
         else if (prev_any) begin
            last_req_len = run_len;
            run_len = 0;
         end
         if (compl) begin
            compl_cnt++;
            chk("compl_one_cycle", prev_compl, 1'b0);
            ev_check(3);
         end
         prev_any = any; prev_rd = rd_en; prev_busy = busy; prev_compl = compl; prev_wr = wr;
         prev_fields = {info, waddr, wlen, cid};
      end
   end

   function automatic vec_t mk(input logic [1:0] typ, input logic [4:0] len, input logic [1:0] id,
                               input logic [54:0] pay, input int dly, input int tlps,
                               input logic [9:0] dw, input logic [31:0] a0, input logic [7:0] dr);
      vec_t v;
      v.typ = typ; v.len = len; v.id = id; v.pay = pay; v.ack_dly = dly;
      v.exp_tlps = tlps; v.exp_len_dw = dw; v.exp_addr0 = a0; v.exp_drop = dr;
      return v;
   endfunction

   task automatic push_vec(input vec_t v);
      ev_t e;
      push_cmd({v.typ, v.len, v.id, v.pay});
      e.info = 55'd0; e.addr = 32'd0; e.len = 10'd0; e.id = v.id;
      if (v.typ == `US_CMD_CPL_TYPE || v.typ == `US_CMD_CPLD_TYPE) begin
         e.kind = (v.typ == `US_CMD_CPL_TYPE) ? 0 : 1;
         e.info = v.pay;
         exp_q.push_back(e);
      end else if (v.typ == `US_CMD_WR32_TYPE) begin
         for (int t = 0; t < v.exp_tlps; t++) begin
            e.kind = 2;
            e.addr = v.exp_addr0 + 32'(t) * (32'(v.exp_len_dw) * 32'd4);
            e.len  = v.exp_len_dw;
            exp_q.push_back(e);
         end
         e.kind = 3; e.addr = 32'd0; e.len = 10'd0;
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_done(input int max_cyc, input string name);
      int n = 0;
      bit ok = 0;
      while (!ok && n < max_cyc) begin
         @(negedge clk); #1;
         n++;
         ok = (fifo_q.size() == 0) && (exp_q.size() == 0) && !busy && !rd_en;
      end
      chk({name, "_finished"}, ok, 1'b1);
   endtask

   task automatic run_vec(input vec_t v, input string name);
      ack_delay = v.ack_dly;
      last_req_len = -1;
      push_vec(v);
      wait_done(20000, name);
      chk({name, "_drop_cnt"}, drop, v.exp_drop);
      if (v.typ != `US_CMD_INVALID) chk({name, "_req_len"}, last_req_len, v.ack_dly);
   endtask

   initial begin
      int   n;
      bit   ok;
      int   compl_before;
      vec_t bv[$];

      vt.push_back(mk(`US_CMD_CPL_TYPE,  5'd3,  2'd1, 55'h12_3456_789A_BCDE, 3, 1, 10'd0,  32'h0, 8'd0));
      vt.push_back(mk(`US_CMD_CPLD_TYPE, 5'd5,  2'd2, 55'h3F_0F0F_A5A5_5A5A, 1, 1, 10'd0,  32'h0, 8'd0));
      vt.push_back(mk(`US_CMD_WR32_TYPE, 5'd6,  2'd3, {23'h1, 32'h1000_0004}, 2, 1, 10'd16, 32'h1000_0004, 8'd0));
      vt.push_back(mk(`US_CMD_WR32_TYPE, 5'd9,  2'd0, {23'h0, 32'h2000_0000}, 1, 4, 10'd32, 32'h2000_0000, 8'd0));
      vt.push_back(mk(`US_CMD_WR32_TYPE, 5'd0,  2'd1, {23'h0, 32'h3000_0013}, 2, 1, 10'd1,  32'h3000_0010, 8'd0));
      vt.push_back(mk(`US_CMD_WR32_TYPE, 5'd8,  2'd2, {23'h0, 32'hFFFF_FF80}, 1, 2, 10'd32, 32'hFFFF_FF80, 8'd0));
      vt.push_back(mk(`US_CMD_WR32_TYPE, 5'd1,  2'd3, {23'h0, 32'h0000_0104}, 1, 1, 10'd1,  32'h0000_0104, 8'd0));
      vt.push_back(mk(`US_CMD_WR32_TYPE, 5'd7,  2'd0, {23'h0, 32'h7000_0040}, 2, 1, 10'd32, 32'h7000_0040, 8'd0));
      vt.push_back(mk(`US_CMD_INVALID,   5'd4,  2'd1, 55'h7,                  1, 0, 10'd0,  32'h0, 8'd1));
      vt.push_back(mk(`US_CMD_CPLD_TYPE, 5'd2,  2'd0, 55'h55_AAAA_0000_1234, 2, 1, 10'd0,  32'h0, 8'd1));
      vt.push_back(mk(`US_CMD_WR32_TYPE, 5'd25, 2'd1, {23'h0, 32'h8000_0000}, 1, 8192, 10'd32, 32'h8000_0000, 8'd1));

      #2 rst_n = 1'b0;
      #1 chk("reset_outputs", {rd_en, cpl, cpld, wr, compl, cid, info, waddr, wlen, busy, drop}, 113'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      #1 chk("idle_after_reset", {rd_en, busy}, 2'b00);

      foreach (vt[i]) run_vec(vt[i], $sformatf("vec%0d", i));

      spurious = 1;
      repeat (6) @(negedge clk);
      #1 chk("idle_ack_ignored", {busy, cpl, cpld, wr, compl}, 5'd0);

      ack_rand = 1;
      bv.push_back(mk(`US_CMD_CPL_TYPE,  5'd2, 2'd1, 55'h01_2345_6789, 1, 1, 10'd0,  32'h0, 8'd1));
      bv.push_back(mk(`US_CMD_WR32_TYPE, 5'd9, 2'd2, {23'h0, 32'h4000_0100}, 1, 4, 10'd32, 32'h4000_0100, 8'd1));
      bv.push_back(mk(`US_CMD_CPLD_TYPE, 5'd3, 2'd3, 55'h7F_FFFF_0000_FFFF, 1, 1, 10'd0, 32'h0, 8'd1));
      bv.push_back(mk(`US_CMD_WR32_TYPE, 5'd2, 2'd0, {23'h0, 32'h5000_0008}, 1, 1, 10'd1, 32'h5000_0008, 8'd1));
      foreach (bv[i]) push_vec(bv[i]);
      wait_done(2000, "burst");
      chk("burst_drop_cnt", drop, 8'd1);
      ack_rand = 0;
      spurious = 0;

      for (int i = 0; i < 260; i++) push_cmd({`US_CMD_INVALID, 5'd0, 2'd0, 55'(i)});
      wait_done(2000, "drop_sat");
      chk("drop_saturates", drop, 8'd255);

      ack_delay = 2;
      push_vec(mk(`US_CMD_WR32_TYPE, 5'd9, 2'd1, {23'h0, 32'h6000_0000}, 2, 4, 10'd32, 32'h6000_0000, 8'd255));
      n = 0; ok = 0;
      while (!ok && n < 200) begin
         @(negedge clk); #1;
         n++;
         ok = (exp_q.size() == 3) && !wr && busy;
      end
      chk("reach_second_gap", ok, 1'b1);
      compl_before = compl_cnt;
      rst_n = 1'b0;
      #1 chk("midcmd_reset_outputs", {rd_en, cpl, cpld, wr, compl, cid, info, waddr, wlen, busy, drop}, 113'd0);
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      #1 chk("after_reset_idle", {busy, cpl, cpld, wr, rd_en}, 5'd0);
      chk("no_compl_after_reset", compl_cnt - compl_before, 0);
      run_vec(vt[0], "post_reset_cpl");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
